// File: rtl/key_defs.sv
// key_defs: shared sizes, debounce FSM encoding and priority helper for key_encoder_83
package key_defs;
  localparam int NUM_KEYS = 8;
  localparam int KEY_CODE_W = 3;
  localparam int KEY_FIFO_DEPTH = 4;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;
  // Lowest set index wins, so key 0 has the highest priority
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) lowest_set = KEY_CODE_W'(i);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through queue; depth must be a power of two
module sync_fifo #(
  parameter int W = 3,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW + 1)'(D);
  assign empty = cnt == '0;
  assign head = empty ? '0 : mem[rp];
  assign do_pop = pop & ~empty;
  // A pop frees the head slot in the same edge, so a full queue may still accept
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/key_encoder_83.sv
// key_encoder_83: debounced 8-to-3 priority encoder for active-low keys with a 4-entry event FIFO
module key_encoder_83
  import key_defs::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key_n,
  output logic [KEY_CODE_W-1:0] code,
  output logic                  valid,
  input  logic                  ready,
  output logic [NUM_KEYS-1:0]   pressed,
  output logic                  overflow
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [NUM_KEYS-1:0] s1, s2, cand, cand_q, new_keys;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic push_q, pop, full, empty;
  logic [KEY_CODE_W-1:0] push_code;
  assign cand = ~s2;
  assign new_keys = cand & ~pressed;
  assign valid = ~empty;
  assign pop = valid & ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      cand_q <= '0;
      state <= S_IDLE;
      cnt <= '0;
      pressed <= '0;
      push_q <= 1'b0;
      push_code <= '0;
      overflow <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      cand_q <= cand;
      push_q <= 1'b0;
      overflow <= push_q & full & ~pop;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (cand != pressed) state <= S_COUNT;
      end else if (cand == pressed) begin
        state <= S_IDLE;
        cnt <= '0;
      end else if (cand != cand_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 2)) begin
        // The entry edge counts as the first stable sample, hence terminal at DB_CYCLES-2
        pressed <= cand;
        state <= S_IDLE;
        cnt <= '0;
        push_q <= |new_keys;
        push_code <= lowest_set(new_keys);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
  sync_fifo #(.W(KEY_CODE_W), .D(KEY_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_q),
    .pop(pop),
    .din(push_code),
    .head(code),
    .full(full),
    .empty(empty)
  );
endmodule
